clk_mon_seq: RTL and testbench
==============================

# clk_mon_seq

Clock-health monitor and MMCM reset sequencer that consumes the outputs of the board clock generator. It drives the MMCM reset and watches the MMCM lock flag. It measures the 200 MHz, 10 MHz and 5 MHz generated clocks against the 50 MHz sys_clkr reference and releases a single system-ready flag only when lock holds and every clock is within tolerance. On lock loss, lock timeout or a frequency fault it re-runs the MMCM reset sequence and counts the retry.

## Interface
Parameters:
- WINDOW, 50000, measurement window in sys_clkr cycles (1 ms)
- DIV_LOG2, 6, monitored-clock divider; one toggle edge every 2^(DIV_LOG2-1) monitored cycles
- EXP_200, 6250, expected edge count per window, 200 MHz clock
- EXP_10, 312, expected edge count per window, 10 MHz clock
- EXP_5, 156, expected edge count per window, 5 MHz clock
- TOL, 4, allowed absolute count deviation
- RST_CYC, 16, MMCM reset pulse length in sys_clkr cycles
- LOCK_TO, 1048576, lock timeout in sys_clkr cycles

Ports:
- sys_clkr  in  1  block clock, 50 MHz
- sys_rst_n  in  1  reset; asynchronous, active-low
- clk200m  in  1  monitored clock; drives the divider only
- clk10m  in  1  monitored clock; drives the divider only
- spi_clk  in  1  monitored clock; drives the divider only
- mmcm_locked  in  1  MMCM lock flag; asynchronous to sys_clkr
- mmcm_rst  out  1  MMCM reset, active-high
- sys_ready  out  1  all clocks locked and in tolerance
- clk_ok  out  3  per-clock result of the last window; bit order {5M, 10M, 200M}
- retry_cnt  out  8  number of re-sequences; saturates at 255
- state  out  2  FSM state: 0 RESET, 1 WAIT_LOCK, 2 MEASURE, 3 RUN

## Operation
- Reset values: mmcm_rst=1, sys_ready=0, clk_ok=0, retry_cnt=0, state=RESET, all counters 0.
- Divider:
  - Each monitored clock runs a DIV_LOG2-bit free counter; its MSB is the toggle.
  - The counter is asynchronously cleared while mmcm_rst=1.
- Edge sampling:
  - Each toggle passes through a 2-flop synchronizer into sys_clkr, followed by an edge-detect flop.
  - Both toggle edges count.
- mmcm_locked passes through a 2-flop synchronizer (lock_s).
- RESET: mmcm_rst=1 for RST_CYC cycles, then go to WAIT_LOCK with mmcm_rst=0.
- WAIT_LOCK: the timeout counter runs.
  - lock_s=1 → MEASURE, window counter and edge counters cleared.
  - Counter reaches LOCK_TO-1 → RESET, retry_cnt++.
- MEASURE:
  - Count edges for WINDOW cycles.
  - At window end, set clk_ok[i] = |cnt_i − EXP_i| ≤ TOL.
  - All three ok → RUN; otherwise → RESET with retry_cnt++.
  - lock_s=0 → RESET with retry_cnt++ immediately, with no window result.
- RUN:
  - sys_ready=1 and windows repeat back-to-back; clk_ok updates every window.
  - Any clk_ok bit fails, or lock_s=0 → RESET, retry_cnt++, sys_ready=0.
- Edge counters are 16 bits wide and saturate at 0xFFFF. The comparison uses a 17-bit signed difference.
- If lock loss and window end occur in the same cycle, lock loss wins and clk_ok is not updated.
- sys_rst_n assertion mid-operation returns all outputs to reset values asynchronously. retry_cnt clears.

## Timing
- mmcm_locked rising → WAIT_LOCK exits after 2 cycles of synchronizer latency plus 1 cycle.
- Window end → clk_ok valid on the next cycle. sys_ready rises in the same cycle as state=RUN.
- Lock loss in RUN → mmcm_rst=1 and sys_ready=0 no later than 3 cycles after mmcm_locked falls.
- After RESET entry, mmcm_rst stays high for exactly RST_CYC cycles.
- Edge-sampling constraint: monitored edge spacing must be ≥ 3 sys_clkr periods. With the default DIV_LOG2, 200 MHz gives 160 ns spacing.
- All outputs are registered in sys_clkr.

## Structure
- Package clk_mon_pkg holds:
  - the state enum (RESET/WAIT_LOCK/MEASURE/RUN, 2-bit);
  - clock index constants (IDX_200=0, IDX_10=1, IDX_5=2);
  - the counter width constant CNT_W=16.
- Sub-module clk_edge_div: one per monitored clock. It contains the divider in the monitored domain plus the 2-flop synchronizer and edge detect into sys_clkr. Its output is a one-cycle edge pulse.
- Mark the synchronizer flops ASYNC_REG.

## Test plan
- Nominal: 200/10/5 MHz clocks, locked rises 1 µs after mmcm_rst falls → one window later, clk_ok=3'b111, sys_ready=1, retry_cnt=0.
- Frequency fault: 10 MHz input at 10.2 MHz → count ≈ 318 > 312+4 → clk_ok=3'b101, mmcm_rst pulses for 16 cycles, retry_cnt=1.
- Lock loss: drop mmcm_locked in RUN → sys_ready=0 and mmcm_rst=1 within 3 cycles, state=RESET.
- Lock timeout: mmcm_locked held 0 → after RST_CYC+LOCK_TO cycles, retry_cnt=1 and mmcm_rst reasserts. Repeat 300 times → retry_cnt holds at 255.
- Stopped clock: spi_clk held 0 in RUN → next window gives clk_ok[2]=0, re-sequence.
- Async reset mid-MEASURE: sys_rst_n pulsed low → mmcm_rst=1, clk_ok=0, retry_cnt=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock-health monitor and MMCM reset sequencer.
`timescale 1ns/1ps
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam int IDX_200 = 0;
    localparam int IDX_10  = 1;
    localparam int IDX_5   = 2;

    localparam int CNT_W = 16;

    // Widen both operands by one bit so a saturated count cannot wrap the difference.
    function automatic logic in_tol(input logic [CNT_W-1:0] cnt,
                                    input logic [CNT_W-1:0] exp_cnt,
                                    input logic [CNT_W-1:0] tol);
        logic signed [CNT_W:0] diff;
        logic signed [CNT_W:0] lim;
        diff = $signed({1'b0, cnt}) - $signed({1'b0, exp_cnt});
        lim  = $signed({1'b0, tol});
        return (diff <= lim) && (diff >= -lim);
    endfunction

endpackage

// File: rtl/clk_edge_div.sv
// Divides one monitored clock in its own domain and returns a one-cycle pulse in
// sys_clkr for every edge of the divided toggle.
`timescale 1ns/1ps
module clk_edge_div
    import clk_mon_pkg::*;
#(
    parameter int DIV_LOG2 = 6
) (
    input  logic sys_clkr,
    input  logic sys_rst_n,
    input  logic clk_mon,
    input  logic div_clr,
    output logic edge_p
);

    logic [DIV_LOG2-1:0] div_q;
    logic [DIV_LOG2-1:0] div_d;

    (* ASYNC_REG = "TRUE" *) logic tgl_meta_q;
    (* ASYNC_REG = "TRUE" *) logic tgl_sync_q;
    logic tgl_dly_q;

    always_comb begin
        div_d = div_q + 1'b1;
    end

    // Held clear while the MMCM is in reset, even if the monitored clock is stopped.
    always_ff @(posedge clk_mon or posedge div_clr) begin
        if (div_clr) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    always_ff @(posedge sys_clkr or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tgl_meta_q <= 1'b0;
            tgl_sync_q <= 1'b0;
            tgl_dly_q  <= 1'b0;
        end else begin
            tgl_meta_q <= div_q[DIV_LOG2-1];
            tgl_sync_q <= tgl_meta_q;
            tgl_dly_q  <= tgl_sync_q;
        end
    end

    assign edge_p = tgl_sync_q ^ tgl_dly_q;

endmodule

// File: rtl/clk_mon_seq.sv
// MMCM reset sequencer that measures three generated clocks against sys_clkr and
// raises sys_ready only while lock holds and every clock is within tolerance.
//
// state        | meaning
// ST_RESET     | mmcm_rst high for RST_CYC cycles
// ST_WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TO
// ST_MEASURE   | first measurement window after lock
// ST_RUN       | sys_ready high, windows repeat back-to-back
`timescale 1ns/1ps
module clk_mon_seq
    import clk_mon_pkg::*;
#(
    parameter int WINDOW   = 50000,
    parameter int DIV_LOG2 = 6,
    parameter int EXP_200  = 6250,
    parameter int EXP_10   = 312,
    parameter int EXP_5    = 156,
    parameter int TOL      = 4,
    parameter int RST_CYC  = 16,
    parameter int LOCK_TO  = 1048576
) (
    input  logic       sys_clkr,
    input  logic       sys_rst_n,
    input  logic       clk200m,
    input  logic       clk10m,
    input  logic       spi_clk,
    input  logic       mmcm_locked,
    output logic       mmcm_rst,
    output logic       sys_ready,
    output logic [2:0] clk_ok,
    output logic [7:0] retry_cnt,
    output logic [1:0] state
);

    localparam int TMR_MAX = (LOCK_TO > WINDOW) ? ((LOCK_TO > RST_CYC) ? LOCK_TO : RST_CYC)
                                                : ((WINDOW > RST_CYC) ? WINDOW : RST_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RST_END  = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_END = TMR_W'(LOCK_TO - 1);
    localparam logic [TMR_W-1:0] WIN_END  = TMR_W'(WINDOW - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       clk_ok_q, clk_ok_d;
    logic [7:0]       retry_q, retry_d;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic             sys_ready_q, sys_ready_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    (* ASYNC_REG = "TRUE" *) logic lock_meta_q;
    (* ASYNC_REG = "TRUE" *) logic lock_s_q;

    logic [2:0] mon_clk;
    logic [2:0] edge_p;
    logic [2:0] ok_w;
    logic       retry_inc;
    logic       cnt_run;

    assign mon_clk = {spi_clk, clk10m, clk200m};

    for (genvar gi = 0; gi < 3; gi++) begin : g_div
        clk_edge_div #(
            .DIV_LOG2 (DIV_LOG2)
        ) u_div (
            .sys_clkr  (sys_clkr),
            .sys_rst_n (sys_rst_n),
            .clk_mon   (mon_clk[gi]),
            .div_clr   (mmcm_rst_q),
            .edge_p    (edge_p[gi])
        );
    end

    always_comb begin
        ok_w          = '0;
        ok_w[IDX_200] = in_tol(cnt_q[IDX_200], CNT_W'(EXP_200), CNT_W'(TOL));
        ok_w[IDX_10]  = in_tol(cnt_q[IDX_10],  CNT_W'(EXP_10),  CNT_W'(TOL));
        ok_w[IDX_5]   = in_tol(cnt_q[IDX_5],   CNT_W'(EXP_5),   CNT_W'(TOL));
    end

    // Every state change restarts the timer, so tmr_d == 0 also marks a window boundary.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q + 1'b1;
        clk_ok_d  = clk_ok_q;
        retry_d   = retry_q;
        retry_inc = 1'b0;

        case (state_q)
            ST_RESET: begin
                if (tmr_q == RST_END) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_MEASURE;
                    tmr_d   = '0;
                end else if (tmr_q == LOCK_END) begin
                    state_d   = ST_RESET;
                    tmr_d     = '0;
                    retry_inc = 1'b1;
                end
            end
            default: begin
                // Lock loss takes priority over a coincident window end.
                if (!lock_s_q) begin
                    state_d   = ST_RESET;
                    tmr_d     = '0;
                    retry_inc = 1'b1;
                end else if (tmr_q == WIN_END) begin
                    clk_ok_d = ok_w;
                    tmr_d    = '0;
                    if (&ok_w) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d   = ST_RESET;
                        retry_inc = 1'b1;
                    end
                end
            end
        endcase

        if (retry_inc && (retry_q != 8'hFF)) begin
            retry_d = retry_q + 8'd1;
        end

        mmcm_rst_d  = (state_d == ST_RESET);
        sys_ready_d = (state_d == ST_RUN);
    end

    always_comb begin
        cnt_run = ((state_q == ST_MEASURE) || (state_q == ST_RUN)) && (tmr_d != '0);
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!cnt_run) begin
                cnt_d[i] = '0;
            end else if (edge_p[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clkr or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_RESET;
            tmr_q       <= '0;
            clk_ok_q    <= '0;
            retry_q     <= '0;
            mmcm_rst_q  <= 1'b1;
            sys_ready_q <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            clk_ok_q    <= clk_ok_d;
            retry_q     <= retry_d;
            mmcm_rst_q  <= mmcm_rst_d;
            sys_ready_q <= sys_ready_d;
            lock_meta_q <= mmcm_locked;
            lock_s_q    <= lock_meta_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign mmcm_rst  = mmcm_rst_q;
    assign sys_ready = sys_ready_q;
    assign clk_ok    = clk_ok_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_clk_mon_seq.sv
// Directed bench for clk_mon_seq with a shortened window and lock timeout.
`timescale 1ns/1ps
module tb_clk_mon_seq;

    localparam int WINDOW   = 5000;
    localparam int DIV_LOG2 = 6;
    localparam int EXP_200  = 625;
    localparam int EXP_10   = 31;
    localparam int EXP_5    = 16;
    localparam int TOL      = 2;
    localparam int RST_CYC  = 16;
    localparam int LOCK_TO  = 64;

    logic       sys_clkr    = 1'b0;
    logic       sys_rst_n   = 1'b0;
    logic       clk200m     = 1'b0;
    logic       clk10m      = 1'b0;
    logic       spi_clk     = 1'b0;
    logic       mmcm_locked = 1'b0;
    logic       mmcm_rst;
    logic       sys_ready;
    logic [2:0] clk_ok;
    logic [7:0] retry_cnt;
    logic [1:0] state;

    real hp10   = 50.0;
    bit  spi_en = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 sys_clkr = ~sys_clkr;
    always #2.5 clk200m = ~clk200m;
    always #(hp10) clk10m = ~clk10m;
    always #100 spi_clk = spi_en ? ~spi_clk : 1'b0;

    clk_mon_seq #(
        .WINDOW   (WINDOW),
        .DIV_LOG2 (DIV_LOG2),
        .EXP_200  (EXP_200),
        .EXP_10   (EXP_10),
        .EXP_5    (EXP_5),
        .TOL      (TOL),
        .RST_CYC  (RST_CYC),
        .LOCK_TO  (LOCK_TO)
    ) dut (
        .sys_clkr    (sys_clkr),
        .sys_rst_n   (sys_rst_n),
        .clk200m     (clk200m),
        .clk10m      (clk10m),
        .spi_clk     (spi_clk),
        .mmcm_locked (mmcm_locked),
        .mmcm_rst    (mmcm_rst),
        .sys_ready   (sys_ready),
        .clk_ok      (clk_ok),
        .retry_cnt   (retry_cnt),
        .state       (state)
    );

    task automatic wait_state(input logic [1:0] s, input int max_cyc, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge sys_clkr);
            if (state === s) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        sys_rst_n   = 1'b0;
        mmcm_locked = 1'b0;
        #35;
        n_checks++; if (mmcm_rst !== 1'b1) begin n_fail++; $display("FAIL reset_mmcm_rst: got %b expected 1", mmcm_rst); end
        n_checks++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sys_ready: got %b expected 0", sys_ready); end
        n_checks++; if (clk_ok !== 3'b000) begin n_fail++; $display("FAIL reset_clk_ok: got %b expected 000", clk_ok); end
        n_checks++; if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        @(negedge sys_clkr);
        sys_rst_n = 1'b1;
        n = 0;
        while (mmcm_rst === 1'b1 && n < 100) begin
            n++;
            @(negedge sys_clkr);
        end
        n_checks++; if (n != RST_CYC) begin n_fail++; $display("FAIL reset_pulse_len: got %0d expected %0d", n, RST_CYC); end
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL reset_to_wait: got %0d expected 1", state); end
    endtask

    task automatic test_nominal();
        repeat (50) @(negedge sys_clkr);
        mmcm_locked = 1'b1;
        repeat (2) @(negedge sys_clkr);
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL lock_sync_latency: got %0d expected 1", state); end
        @(negedge sys_clkr);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL lock_to_measure: got %0d expected 2", state); end
        repeat (WINDOW - 1) @(negedge sys_clkr);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL window_len_state: got %0d expected 2", state); end
        n_checks++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL window_len_ready: got %b expected 0", sys_ready); end
        @(negedge sys_clkr);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL nominal_state: got %0d expected 3", state); end
        n_checks++; if (sys_ready !== 1'b1) begin n_fail++; $display("FAIL nominal_ready: got %b expected 1", sys_ready); end
        n_checks++; if (clk_ok !== 3'b111) begin n_fail++; $display("FAIL nominal_clk_ok: got %b expected 111", clk_ok); end
        n_checks++; if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL nominal_retry: got %0d expected 0", retry_cnt); end
        n_checks++; if (mmcm_rst !== 1'b0) begin n_fail++; $display("FAIL nominal_mmcm_rst: got %b expected 0", mmcm_rst); end
        repeat (WINDOW) @(negedge sys_clkr);
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL back_to_back_state: got %0d expected 3", state); end
        n_checks++; if (clk_ok !== 3'b111) begin n_fail++; $display("FAIL back_to_back_clk_ok: got %b expected 111", clk_ok); end
    endtask

    task automatic test_lock_loss();
        mmcm_locked = 1'b0;
        repeat (2) @(negedge sys_clkr);
        n_checks++; if (sys_ready !== 1'b1) begin n_fail++; $display("FAIL lock_loss_early: got %b expected 1", sys_ready); end
        @(negedge sys_clkr);
        n_checks++; if (mmcm_rst !== 1'b1) begin n_fail++; $display("FAIL lock_loss_mmcm_rst: got %b expected 1", mmcm_rst); end
        n_checks++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL lock_loss_ready: got %b expected 0", sys_ready); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL lock_loss_state: got %0d expected 0", state); end
        n_checks++; if (retry_cnt !== 8'd1) begin n_fail++; $display("FAIL lock_loss_retry: got %0d expected 1", retry_cnt); end
        n_checks++; if (clk_ok !== 3'b111) begin n_fail++; $display("FAIL lock_loss_clk_ok: got %b expected 111", clk_ok); end
    endtask

    task automatic test_freq_fault();
        bit hit;
        int n;
        hp10 = 40.0;
        wait_state(2'd1, 100, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL freq_wait_lock: timeout, state %0d expected 1", state); end
        mmcm_locked = 1'b1;
        wait_state(2'd2, 10, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL freq_measure: timeout, state %0d expected 2", state); end
        wait_state(2'd0, WINDOW + 100, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL freq_reseq: timeout, state %0d expected 0", state); end
        mmcm_locked = 1'b0;
        n_checks++; if (clk_ok !== 3'b101) begin n_fail++; $display("FAIL freq_clk_ok: got %b expected 101", clk_ok); end
        n_checks++; if (retry_cnt !== 8'd2) begin n_fail++; $display("FAIL freq_retry: got %0d expected 2", retry_cnt); end
        n = 0;
        while (mmcm_rst === 1'b1 && n < 100) begin
            n++;
            @(negedge sys_clkr);
        end
        n_checks++; if (n != RST_CYC) begin n_fail++; $display("FAIL freq_pulse_len: got %0d expected %0d", n, RST_CYC); end
        hp10 = 50.0;
    endtask

    task automatic test_stopped_clock();
        bit hit;
        wait_state(2'd1, 100, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL stop_wait_lock: timeout, state %0d expected 1", state); end
        mmcm_locked = 1'b1;
        wait_state(2'd3, WINDOW + 100, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL stop_run: timeout, state %0d expected 3", state); end
        n_checks++; if (clk_ok !== 3'b111) begin n_fail++; $display("FAIL stop_pre_clk_ok: got %b expected 111", clk_ok); end
        spi_en = 1'b0;
        wait_state(2'd0, 2 * WINDOW + 100, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL stop_reseq: timeout, state %0d expected 0", state); end
        n_checks++; if (clk_ok !== 3'b011) begin n_fail++; $display("FAIL stop_clk_ok: got %b expected 011", clk_ok); end
        n_checks++; if (retry_cnt !== 8'd3) begin n_fail++; $display("FAIL stop_retry: got %0d expected 3", retry_cnt); end
        n_checks++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL stop_ready: got %b expected 0", sys_ready); end
        mmcm_locked = 1'b0;
        spi_en      = 1'b1;
    endtask

    task automatic test_async_reset();
        bit hit;
        wait_state(2'd1, 100, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL arst_wait_lock: timeout, state %0d expected 1", state); end
        mmcm_locked = 1'b1;
        wait_state(2'd2, 10, hit);
        n_checks++; if (!hit) begin n_fail++; $display("FAIL arst_measure: timeout, state %0d expected 2", state); end
        repeat (100) @(negedge sys_clkr);
        n_checks++; if (retry_cnt !== 8'd3) begin n_fail++; $display("FAIL arst_pre_retry: got %0d expected 3", retry_cnt); end
        #3;
        sys_rst_n = 1'b0;
        #1;
        n_checks++; if (mmcm_rst !== 1'b1) begin n_fail++; $display("FAIL arst_mmcm_rst: got %b expected 1", mmcm_rst); end
        n_checks++; if (clk_ok !== 3'b000) begin n_fail++; $display("FAIL arst_clk_ok: got %b expected 000", clk_ok); end
        n_checks++; if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL arst_retry: got %0d expected 0", retry_cnt); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL arst_state: got %0d expected 0", state); end
        mmcm_locked = 1'b0;
    endtask

    task automatic test_lock_timeout();
        @(negedge sys_clkr);
        sys_rst_n = 1'b1;
        repeat (RST_CYC + LOCK_TO - 1) @(negedge sys_clkr);
        n_checks++; if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL timeout_early_retry: got %0d expected 0", retry_cnt); end
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL timeout_early_state: got %0d expected 1", state); end
        @(negedge sys_clkr);
        n_checks++; if (retry_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_retry: got %0d expected 1", retry_cnt); end
        n_checks++; if (mmcm_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_mmcm_rst: got %b expected 1", mmcm_rst); end
        repeat (253 * (RST_CYC + LOCK_TO)) @(negedge sys_clkr);
        n_checks++; if (retry_cnt !== 8'd254) begin n_fail++; $display("FAIL timeout_retry_254: got %0d expected 254", retry_cnt); end
        repeat (RST_CYC + LOCK_TO) @(negedge sys_clkr);
        n_checks++; if (retry_cnt !== 8'd255) begin n_fail++; $display("FAIL timeout_retry_255: got %0d expected 255", retry_cnt); end
        repeat (46 * (RST_CYC + LOCK_TO)) @(negedge sys_clkr);
        n_checks++; if (retry_cnt !== 8'd255) begin n_fail++; $display("FAIL timeout_retry_sat: got %0d expected 255", retry_cnt); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL timeout_sat_state: got %0d expected 0", state); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss();
        test_freq_fault();
        test_stopped_clock();
        test_async_reset();
        test_lock_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
